// File: rtl/poly_note_ctrl.sv
// Polyphonic note front-end: per-key debounce, source select, serial note-on/off event stream
// with first-free voice allocation, and the saturating pitch-shift register.
module poly_note_ctrl #(
  parameter int unsigned NKEYS     = 10,
  parameter int unsigned NVOICES   = 4,
  parameter int unsigned DB_COUNT  = 255,
  parameter int unsigned DB_WIDTH  = 8,
  parameter int unsigned SHIFT_MAX = 12,
  localparam int unsigned KW = (NKEYS > 1) ? $clog2(NKEYS) : 1,
  localparam int unsigned VW = (NVOICES > 1) ? $clog2(NVOICES) : 1,
  localparam int unsigned SW = $clog2(2 * SHIFT_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NKEYS-1:0]      key_raw,
  input  logic [NKEYS-1:0]      dist_note,
  input  logic [NKEYS-1:0]      auto_note,
  input  logic [1:0]            src_sel,
  input  logic                  shift_up,
  input  logic                  shift_dn,
  output logic [SW-1:0]         pitch_shift,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic                  ev_on,
  output logic [KW-1:0]         ev_key,
  output logic [VW-1:0]         ev_voice,
  output logic [NVOICES-1:0]    voice_active,
  output logic [NVOICES*KW-1:0] voice_key,
  output logic [VW:0]           active_cnt
);

  localparam logic [SW-1:0] ShiftCentre = SW'(SHIFT_MAX);
  localparam logic [SW-1:0] ShiftTop    = SW'(2 * SHIFT_MAX);

  logic [NKEYS-1:0][DB_WIDTH-1:0] db_cnt_q, db_cnt_d;
  logic [NKEYS-1:0]               db_out_q, db_out_d;
  logic [NKEYS-1:0]               note_vec_q, note_vec_d;
  logic [NKEYS-1:0]               held_q, held_d;
  logic [NVOICES-1:0]             voice_active_q, voice_active_d;
  logic [NVOICES-1:0][KW-1:0]     voice_key_q, voice_key_d;
  logic                           ev_valid_q, ev_valid_d;
  logic                           ev_on_q, ev_on_d;
  logic [KW-1:0]                  ev_key_q, ev_key_d;
  logic [VW-1:0]                  ev_voice_q, ev_voice_d;
  logic [SW-1:0]                  pitch_q, pitch_d;

  // Scanner decode
  logic [NKEYS-1:0] diff;
  logic             scan_en;
  logic             found;
  logic             is_press;
  logic [KW-1:0]    k_sel;
  logic             rel_hit;
  logic [VW-1:0]    rel_v;
  logic             free_hit;
  logic [VW-1:0]    free_v;

  // Debounce: output toggles once the raw input has disagreed for DB_COUNT+1 cycles in a row.
  always_comb begin
    db_cnt_d = db_cnt_q;
    db_out_d = db_out_q;
    for (int k = 0; k < int'(NKEYS); k++) begin
      if (key_raw[k] != db_out_q[k]) begin
        if (db_cnt_q[k] == DB_WIDTH'(DB_COUNT)) begin
          db_out_d[k] = ~db_out_q[k];
          db_cnt_d[k] = '0;
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end else begin
        db_cnt_d[k] = '0;
      end
    end
  end

  always_comb begin
    note_vec_d = '0;
    unique case (src_sel)
      2'd0:    note_vec_d = db_out_q;
      2'd1:    note_vec_d = dist_note;
      2'd2:    note_vec_d = auto_note;
      2'd3:    note_vec_d = '0;
      default: note_vec_d = '0;
    endcase
  end

  // Lowest differing key, the voice holding it, and the lowest free voice.
  always_comb begin
    diff     = note_vec_q ^ held_q;
    scan_en  = !ev_valid_q || ev_ready;
    found    = 1'b0;
    is_press = 1'b0;
    k_sel    = '0;
    for (int k = int'(NKEYS) - 1; k >= 0; k--) begin
      if (diff[k]) begin
        found    = 1'b1;
        is_press = note_vec_q[k];
        k_sel    = KW'(k);
      end
    end
    rel_hit  = 1'b0;
    rel_v    = '0;
    free_hit = 1'b0;
    free_v   = '0;
    for (int v = int'(NVOICES) - 1; v >= 0; v--) begin
      if (voice_active_q[v] && (voice_key_q[v] == k_sel)) begin
        rel_hit = 1'b1;
        rel_v   = VW'(v);
      end
      if (!voice_active_q[v]) begin
        free_hit = 1'b1;
        free_v   = VW'(v);
      end
    end
  end

  always_comb begin
    held_d         = held_q;
    voice_active_d = voice_active_q;
    voice_key_d    = voice_key_q;
    ev_on_d        = ev_on_q;
    ev_key_d       = ev_key_q;
    ev_voice_d     = ev_voice_q;
    ev_valid_d     = ev_valid_q && !ev_ready;
    if (scan_en && found) begin
      held_d[k_sel] = is_press;
      if (!is_press) begin
        // A key committed without a voice releases silently.
        if (rel_hit) begin
          voice_active_d[rel_v] = 1'b0;
          ev_valid_d            = 1'b1;
          ev_on_d               = 1'b0;
          ev_key_d              = k_sel;
          ev_voice_d            = rel_v;
        end
      end else if (free_hit) begin
        voice_active_d[free_v] = 1'b1;
        voice_key_d[free_v]    = k_sel;
        ev_valid_d             = 1'b1;
        ev_on_d                = 1'b1;
        ev_key_d               = k_sel;
        ev_voice_d             = free_v;
      end
    end
  end

  always_comb begin
    pitch_d = pitch_q;
    if (shift_up && !shift_dn && (pitch_q != ShiftTop)) begin
      pitch_d = pitch_q + 1'b1;
    end else if (shift_dn && !shift_up && (pitch_q != '0)) begin
      pitch_d = pitch_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q       <= '0;
      db_out_q       <= '0;
      note_vec_q     <= '0;
      held_q         <= '0;
      voice_active_q <= '0;
      voice_key_q    <= '0;
      ev_valid_q     <= 1'b0;
      ev_on_q        <= 1'b0;
      ev_key_q       <= '0;
      ev_voice_q     <= '0;
      pitch_q        <= ShiftCentre;
    end else begin
      db_cnt_q       <= db_cnt_d;
      db_out_q       <= db_out_d;
      note_vec_q     <= note_vec_d;
      held_q         <= held_d;
      voice_active_q <= voice_active_d;
      voice_key_q    <= voice_key_d;
      ev_valid_q     <= ev_valid_d;
      ev_on_q        <= ev_on_d;
      ev_key_q       <= ev_key_d;
      ev_voice_q     <= ev_voice_d;
      pitch_q        <= pitch_d;
    end
  end

  always_comb begin
    active_cnt = '0;
    for (int v = 0; v < int'(NVOICES); v++) begin
      active_cnt = active_cnt + (VW + 1)'(voice_active_q[v]);
    end
  end

  assign pitch_shift  = pitch_q;
  assign ev_valid     = ev_valid_q;
  assign ev_on        = ev_on_q;
  assign ev_key       = ev_key_q;
  assign ev_voice     = ev_voice_q;
  assign voice_active = voice_active_q;
  assign voice_key    = voice_key_q;

endmodule

// File: tb/tb_poly_note_ctrl.sv
// Self-checking bench for poly_note_ctrl: directed scenarios plus randomized vector changes
// checked against a set-level voice-allocation model.
module tb_poly_note_ctrl;

  localparam int NKEYS     = 10;
  localparam int NVOICES   = 4;
  localparam int DB_COUNT  = 255;
  localparam int SHIFT_MAX = 12;
  localparam int KW        = 4;
  localparam int VW        = 2;
  localparam int SW        = 5;

  typedef logic [KW+VW:0] ev_t;

  logic                  clk;
  logic                  rst_n;
  logic [NKEYS-1:0]      key_raw;
  logic [NKEYS-1:0]      dist_note;
  logic [NKEYS-1:0]      auto_note;
  logic [1:0]            src_sel;
  logic                  shift_up;
  logic                  shift_dn;
  logic [SW-1:0]         pitch_shift;
  logic                  ev_valid;
  logic                  ev_ready;
  logic                  ev_on;
  logic [KW-1:0]         ev_key;
  logic [VW-1:0]         ev_voice;
  logic [NVOICES-1:0]    voice_active;
  logic [NVOICES*KW-1:0] voice_key;
  logic [VW:0]           active_cnt;

  int  n_tests;
  int  n_fail;
  ev_t got_q[$];

  poly_note_ctrl #(
    .NKEYS    (NKEYS),
    .NVOICES  (NVOICES),
    .DB_COUNT (DB_COUNT),
    .DB_WIDTH (8),
    .SHIFT_MAX(SHIFT_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .dist_note   (dist_note),
    .auto_note   (auto_note),
    .src_sel     (src_sel),
    .shift_up    (shift_up),
    .shift_dn    (shift_dn),
    .pitch_shift (pitch_shift),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_on       (ev_on),
    .ev_key      (ev_key),
    .ev_voice    (ev_voice),
    .voice_active(voice_active),
    .voice_key   (voice_key),
    .active_cnt  (active_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ev_t mk_ev(input bit on, input int k, input int v);
    return {on, KW'(k), VW'(v)};
  endfunction

  // One cycle: drive ev_ready at the falling edge and log the handshake the next rising edge takes.
  task automatic step(input logic rdy);
    @(negedge clk);
    ev_ready = rdy;
    #1;
    if (ev_valid && ev_ready) got_q.push_back({ev_on, ev_key, ev_voice});
  endtask

  task automatic do_reset();
    key_raw   = '0;
    dist_note = '0;
    auto_note = '0;
    src_sel   = 2'd0;
    shift_up  = 1'b0;
    shift_dn  = 1'b0;
    ev_ready  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ev_valid: got %0h want 0", ev_valid); end
    n_tests++; if (ev_on !== 1'b0) begin n_fail++; $display("FAIL rst_ev_on: got %0h want 0", ev_on); end
    n_tests++; if (ev_key !== '0) begin n_fail++; $display("FAIL rst_ev_key: got %0h want 0", ev_key); end
    n_tests++; if (ev_voice !== '0) begin n_fail++; $display("FAIL rst_ev_voice: got %0h want 0", ev_voice); end
    n_tests++; if (voice_active !== '0) begin n_fail++; $display("FAIL rst_voice_active: got %0h want 0", voice_active); end
    n_tests++; if (voice_key !== '0) begin n_fail++; $display("FAIL rst_voice_key: got %0h want 0", voice_key); end
    n_tests++; if (active_cnt !== '0) begin n_fail++; $display("FAIL rst_active_cnt: got %0h want 0", active_cnt); end
    n_tests++; if (pitch_shift !== SW'(SHIFT_MAX)) begin n_fail++; $display("FAIL rst_pitch: got %0d want %0d", pitch_shift, SHIFT_MAX); end
    // A pending event must vanish as soon as reset is asserted, without a clock edge.
    src_sel   = 2'd1;
    dist_note = 10'h001;
    repeat (3) step(1'b0);
    n_tests++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pending_setup: got %0h want 1", ev_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_clear: got %0h want 0", ev_valid); end
    n_tests++; if (voice_active !== '0) begin n_fail++; $display("FAIL rst_async_voices: got %0h want 0", voice_active); end
    do_reset();
  endtask

  task automatic test_debounce();
    int bad;
    int lat;
    do_reset();
    src_sel = 2'd0;
    bad     = 0;
    for (int t = 0; t < 4; t++) begin
      key_raw[3] = ~key_raw[3];
      for (int i = 0; i < 100; i++) begin
        step(1'b1);
        if (ev_valid) bad++;
      end
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL db_bounce_quiet: got %0d event cycles want 0", bad); end
    key_raw[3] = 1'b1;
    lat        = 0;
    for (int i = 1; i <= DB_COUNT + 20; i++) begin
      step(1'b1);
      if (ev_valid && lat == 0) lat = i;
    end
    n_tests++; if (lat !== DB_COUNT + 3) begin n_fail++; $display("FAIL db_latency: got %0d want %0d", lat, DB_COUNT + 3); end
    n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL db_event_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_tests++;
      if (got_q[0] !== mk_ev(1, 3, 0)) begin n_fail++; $display("FAIL db_event: got %0h want %0h", got_q[0], mk_ev(1, 3, 0)); end
    end
  endtask

  task automatic test_polyphony();
    int sz1;
    int sz2;
    int sz5;
    do_reset();
    src_sel   = 2'd2;
    auto_note = 10'h01F;
    step(1'b1); sz1 = got_q.size();
    step(1'b1); sz2 = got_q.size();
    repeat (3) step(1'b1);
    sz5 = got_q.size();
    repeat (8) step(1'b1);
    n_tests++; if (sz1 !== 0 || sz2 !== 1) begin n_fail++; $display("FAIL poly_latency: got %0d/%0d want 0/1", sz1, sz2); end
    n_tests++; if (sz5 !== 4) begin n_fail++; $display("FAIL poly_rate: got %0d events by cycle 5 want 4", sz5); end
    n_tests++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL poly_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== mk_ev(1, i, i)) begin n_fail++; $display("FAIL poly_event%0d: got %0h want %0h", i, got_q[i], mk_ev(1, i, i)); end
    end
    n_tests++; if (active_cnt !== 3'd4) begin n_fail++; $display("FAIL poly_active_cnt: got %0d want 4", active_cnt); end
    n_tests++; if (voice_key !== 16'h3210) begin n_fail++; $display("FAIL poly_voice_key: got %0h want 3210", voice_key); end
    got_q.delete();
    auto_note = 10'h00F;
    repeat (8) step(1'b1);
    n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL poly_unvoiced_release: got %0d events want 0", got_q.size()); end
    got_q.delete();
    auto_note = 10'h00D;
    repeat (8) step(1'b1);
    n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL poly_release_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_tests++;
      if (got_q[0] !== mk_ev(0, 1, 1)) begin n_fail++; $display("FAIL poly_release: got %0h want %0h", got_q[0], mk_ev(0, 1, 1)); end
    end
    n_tests++; if (voice_active !== 4'b1101) begin n_fail++; $display("FAIL poly_voice_active: got %0b want 1101", voice_active); end
  endtask

  task automatic test_back_pressure();
    int   bad;
    ev_t  first;
    do_reset();
    src_sel   = 2'd1;
    dist_note = 10'h022;
    repeat (2) step(1'b0);
    first = {ev_on, ev_key, ev_voice};
    n_tests++; if (ev_valid !== 1'b1 || first !== mk_ev(1, 1, 0)) begin
      n_fail++; $display("FAIL bp_first: got valid=%0h ev=%0h want valid=1 ev=%0h", ev_valid, first, mk_ev(1, 1, 0));
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      if (!ev_valid || {ev_on, ev_key, ev_voice} !== mk_ev(1, 1, 0)) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    step(1'b1);
    step(1'b1);
    n_tests++; if (ev_valid !== 1'b1 || {ev_on, ev_key, ev_voice} !== mk_ev(1, 5, 1)) begin
      n_fail++; $display("FAIL bp_second: got valid=%0h ev=%0h want valid=1 ev=%0h", ev_valid, {ev_on, ev_key, ev_voice}, mk_ev(1, 5, 1));
    end
    step(1'b0);
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0h want 0", ev_valid); end
    n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", got_q.size()); end
  endtask

  task automatic test_source_switch();
    do_reset();
    src_sel = 2'd0;
    key_raw = 10'b00_0010_0100;
    repeat (DB_COUNT + 10) step(1'b1);
    n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL src_press_count: got %0d want 2", got_q.size()); end
    got_q.delete();
    src_sel = 2'd3;
    repeat (10) step(1'b1);
    n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL src_off_count: got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_tests++; if (got_q[0] !== mk_ev(0, 2, 0)) begin n_fail++; $display("FAIL src_off0: got %0h want %0h", got_q[0], mk_ev(0, 2, 0)); end
      n_tests++; if (got_q[1] !== mk_ev(0, 5, 1)) begin n_fail++; $display("FAIL src_off1: got %0h want %0h", got_q[1], mk_ev(0, 5, 1)); end
    end
    n_tests++; if (voice_active !== '0 || active_cnt !== '0) begin
      n_fail++; $display("FAIL src_silent: got active=%0b cnt=%0d want 0/0", voice_active, active_cnt);
    end
  endtask

  task automatic test_pitch();
    int p;
    int up;
    int dn;
    do_reset();
    p = SHIFT_MAX;
    for (int i = 0; i < 13; i++) begin
      shift_up = 1'b1; step(1'b0); shift_up = 1'b0;
      p = (p + 1 > 2 * SHIFT_MAX) ? 2 * SHIFT_MAX : p + 1;
      n_tests++; if (pitch_shift !== SW'(p)) begin n_fail++; $display("FAIL pitch_up%0d: got %0d want %0d", i, pitch_shift, p); end
    end
    shift_up = 1'b1; shift_dn = 1'b1; step(1'b0); shift_up = 1'b0; shift_dn = 1'b0;
    n_tests++; if (pitch_shift !== SW'(24)) begin n_fail++; $display("FAIL pitch_both: got %0d want 24", pitch_shift); end
    for (int i = 0; i < 30; i++) begin
      shift_dn = 1'b1; step(1'b0); shift_dn = 1'b0;
      p = (p == 0) ? 0 : p - 1;
      n_tests++; if (pitch_shift !== SW'(p)) begin n_fail++; $display("FAIL pitch_dn%0d: got %0d want %0d", i, pitch_shift, p); end
    end
    for (int i = 0; i < 80; i++) begin
      up = $urandom_range(0, 1);
      dn = $urandom_range(0, 1);
      shift_up = up[0]; shift_dn = dn[0];
      step(1'b0);
      if (up == 1 && dn == 0) p = (p == 2 * SHIFT_MAX) ? p : p + 1;
      if (dn == 1 && up == 0) p = (p == 0) ? 0 : p - 1;
      n_tests++; if (pitch_shift !== SW'(p)) begin n_fail++; $display("FAIL pitch_rand%0d: got %0d want %0d", i, pitch_shift, p); end
    end
    shift_up = 1'b0; shift_dn = 1'b0;
  endtask

  // Reference: keys settle in ascending order; releases free their voice, presses take the
  // lowest free voice or go unvoiced when none is free.
  task automatic test_random();
    bit   held[NKEYS];
    int   voice_of[NKEYS];
    bit   busy[NVOICES];
    ev_t  exp_q[$];
    logic [NKEYS-1:0] nv;
    int   cnt;
    do_reset();
    src_sel = 2'd2;
    foreach (held[k]) begin held[k] = 0; voice_of[k] = -1; end
    foreach (busy[v]) busy[v] = 0;
    for (int t = 0; t < 25; t++) begin
      nv = NKEYS'($urandom);
      exp_q.delete();
      got_q.delete();
      for (int k = 0; k < NKEYS; k++) begin
        if (held[k] && !nv[k]) begin
          if (voice_of[k] >= 0) begin
            exp_q.push_back(mk_ev(0, k, voice_of[k]));
            busy[voice_of[k]] = 0;
            voice_of[k] = -1;
          end
        end else if (!held[k] && nv[k]) begin
          for (int v = 0; v < NVOICES; v++) begin
            if (!busy[v] && voice_of[k] < 0) begin
              busy[v] = 1;
              voice_of[k] = v;
              exp_q.push_back(mk_ev(1, k, v));
            end
          end
        end
        held[k] = nv[k];
      end
      auto_note = nv;
      for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)));
      repeat (16) step(1'b1);
      n_tests++; if (got_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_tests++; if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_ev%0d: got %0h want %0h", t, i, got_q[i], exp_q[i]);
        end
      end
      cnt = 0;
      for (int v = 0; v < NVOICES; v++) begin
        cnt += busy[v];
        n_tests++; if (voice_active[v] !== busy[v]) begin
          n_fail++; $display("FAIL rand%0d_active%0d: got %0b want %0b", t, v, voice_active[v], busy[v]);
        end
      end
      for (int k = 0; k < NKEYS; k++) begin
        if (voice_of[k] >= 0) begin
          n_tests++; if (voice_key[voice_of[k]*KW +: KW] !== KW'(k)) begin
            n_fail++; $display("FAIL rand%0d_vkey%0d: got %0d want %0d", t, voice_of[k], voice_key[voice_of[k]*KW +: KW], k);
          end
        end
      end
      n_tests++; if (active_cnt !== 3'(cnt)) begin
        n_fail++; $display("FAIL rand%0d_active_cnt: got %0d want %0d", t, active_cnt, cnt);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_debounce();
    test_polyphony();
    test_back_pressure();
    test_source_switch();
    test_pitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
